// File: rtl/sequenciador_verifica_macro.sv
// Win/draw check sequencer for one 3x3 micro board. It reads the 9 cells of the
// selected macro cell from the board RAM, then evaluates the 8 lines for the player who just moved.
module sequenciador_verifica_macro #(
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar_verif,
    input  logic [3:0]        macro_sel,
    input  logic              jogador,
    input  logic [1:0]        mem_dado,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_le,
    output logic              ocupado,
    output logic              fim_verif,
    output logic              venceu,
    output logic              empate,
    output logic [2:0]        linha,
    output logic              erro,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        LEITURA = 4'h1,
        CAPTURA = 4'h2,
        AVALIA  = 4'h3,
        FIM     = 4'hF
    } estado_t;

    estado_t           estado;
    estado_t           prox_estado;
    logic [3:0]        cnt;
    logic [3:0]        macro_reg;
    logic              jogador_reg;
    logic [1:0]        shadow [9];
    logic [ADDR_W-1:0] base_addr;
    logic [1:0]        codigo;
    logic [8:0]        eh_jog;
    logic [8:0]        cheio;
    logic [7:0]        match;
    logic [2:0]        linha_calc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = OCIOSO;
        case (estado)
            OCIOSO: begin
                if (!iniciar_verif) begin
                    prox_estado = OCIOSO;
                end else if (macro_sel > 4'd8) begin
                    prox_estado = FIM;
                end else begin
                    prox_estado = LEITURA;
                end
            end
            LEITURA: prox_estado = (cnt == 4'd8) ? CAPTURA : LEITURA;
            CAPTURA: prox_estado = AVALIA;
            AVALIA:  prox_estado = FIM;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // Address is decoded from the latched macro cell and cnt only, so nothing
    // from the inputs reaches the memory port combinationally.
    assign base_addr = ADDR_W'(macro_reg) * ADDR_W'(9);
    assign mem_addr  = (estado == LEITURA) ? (base_addr + ADDR_W'(cnt)) : '0;
    assign mem_le    = (estado == LEITURA);
    assign ocupado   = (estado != OCIOSO);
    assign fim_verif = (estado == FIM);
    assign db_estado = estado;

    always_comb begin
        codigo = jogador_reg ? 2'b10 : 2'b01;
        eh_jog = '0;
        cheio  = '0;
        for (int i = 0; i < 9; i++) begin
            eh_jog[i] = (shadow[i] == codigo);
            cheio[i]  = (shadow[i] == 2'b01) || (shadow[i] == 2'b10);
        end
        match[0] = eh_jog[0] & eh_jog[1] & eh_jog[2];
        match[1] = eh_jog[3] & eh_jog[4] & eh_jog[5];
        match[2] = eh_jog[6] & eh_jog[7] & eh_jog[8];
        match[3] = eh_jog[0] & eh_jog[3] & eh_jog[6];
        match[4] = eh_jog[1] & eh_jog[4] & eh_jog[7];
        match[5] = eh_jog[2] & eh_jog[5] & eh_jog[8];
        match[6] = eh_jog[0] & eh_jog[4] & eh_jog[8];
        match[7] = eh_jog[2] & eh_jog[4] & eh_jog[6];
        linha_calc = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (match[i]) begin
                linha_calc = 3'(i);
            end
        end
    end

    // RAM data lags the address by one cycle, so the cell issued at cnt-1
    // arrives while cnt is current; the last cell lands during CAPTURA.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            macro_reg   <= '0;
            jogador_reg <= 1'b0;
            venceu      <= 1'b0;
            empate      <= 1'b0;
            linha       <= '0;
            erro        <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= 2'b00;
            end
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar_verif) begin
                        macro_reg   <= macro_sel;
                        jogador_reg <= jogador;
                        venceu      <= 1'b0;
                        empate      <= 1'b0;
                        linha       <= '0;
                        erro        <= (macro_sel > 4'd8);
                        cnt         <= '0;
                    end
                end
                LEITURA: begin
                    if (cnt != 4'd0) begin
                        shadow[cnt - 4'd1] <= mem_dado;
                    end
                    if (cnt != 4'd8) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPTURA: begin
                    shadow[8] <= mem_dado;
                end
                AVALIA: begin
                    venceu <= |match;
                    linha  <= linha_calc;
                    empate <= ~(|match) & (&cheio);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_verifica_macro.sv
// Self-checking bench: synchronous board RAM model plus a line-table reference
// model of the win/draw rules, directed scenarios and randomized boards.
module tb_sequenciador_verifica_macro;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar_verif = 1'b0;
    logic [3:0] macro_sel = '0;
    logic       jogador = 1'b0;
    logic [1:0] mem_dado = 2'b00;
    logic [6:0] mem_addr;
    logic       mem_le;
    logic       ocupado;
    logic       fim_verif;
    logic       venceu;
    logic       empate;
    logic [2:0] linha;
    logic       erro;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] mem [0:80];
    int linhas [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    sequenciador_verifica_macro #(.ADDR_W(7)) dut (
        .clock(clock), .reset(reset), .iniciar_verif(iniciar_verif),
        .macro_sel(macro_sel), .jogador(jogador), .mem_dado(mem_dado),
        .mem_addr(mem_addr), .mem_le(mem_le), .ocupado(ocupado),
        .fim_verif(fim_verif), .venceu(venceu), .empate(empate),
        .linha(linha), .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_le) mem_dado <= mem[mem_addr];
    end

    // Reference rules: lowest-index line fully owned by the player wins; draw
    // only when no win and every cell holds 01 or 10 (11 counts as empty).
    task automatic modelo(input int ms, input logic jg, output logic v,
                          output logic e, output logic [2:0] l);
        logic [1:0] code;
        int ocupadas;
        code = jg ? 2'b10 : 2'b01;
        v = 1'b0;
        l = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mem[ms*9+linhas[i][0]] == code && mem[ms*9+linhas[i][1]] == code &&
                mem[ms*9+linhas[i][2]] == code) begin
                v = 1'b1;
                l = 3'(i);
            end
        end
        ocupadas = 0;
        for (int i = 0; i < 9; i++) begin
            if (mem[ms*9+i] == 2'b01 || mem[ms*9+i] == 2'b10) ocupadas++;
        end
        e = !v && (ocupadas == 9);
    endtask

    task automatic limpa_mem();
        for (int i = 0; i < 81; i++) mem[i] = 2'b00;
    endtask

    // One full check; cycle c is the c-th clock period after the accepting edge.
    task automatic test_verificacao(input int ms, input logic jg, input string nome);
        logic ve, ee;
        logic [2:0] le;
        int fims;
        fims = 0;
        modelo(ms, jg, ve, ee, le);
        @(negedge clock);
        iniciar_verif = 1'b1;
        macro_sel = 4'(ms);
        jogador = jg;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clock);
            iniciar_verif = 1'b0;
            vectors++;
            if (mem_le !== (c <= 9)) begin
                miscompares++;
                $display("[TB] FAIL %s mem_le c%0d: got %b expected %b", nome, c, mem_le, (c <= 9));
            end
            vectors++;
            if (mem_addr !== ((c <= 9) ? 7'(ms*9 + c - 1) : 7'd0)) begin
                miscompares++;
                $display("[TB] FAIL %s mem_addr c%0d: got %0d expected %0d", nome, c, mem_addr,
                         (c <= 9) ? ms*9 + c - 1 : 0);
            end
            vectors++;
            if (fim_verif !== (c == 12)) begin
                miscompares++;
                $display("[TB] FAIL %s fim_verif c%0d: got %b expected %b", nome, c, fim_verif, (c == 12));
            end
            vectors++;
            if (ocupado !== (c <= 12)) begin
                miscompares++;
                $display("[TB] FAIL %s ocupado c%0d: got %b expected %b", nome, c, ocupado, (c <= 12));
            end
            if (fim_verif === 1'b1) fims++;
            if (c <= 11) begin
                vectors++;
                if (venceu !== 1'b0 || empate !== 1'b0 || erro !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s cleared c%0d: got v%b e%b err%b expected 000", nome, c, venceu, empate, erro);
                end
            end else begin
                vectors++;
                if (venceu !== ve || empate !== ee || erro !== 1'b0 || (ve && linha !== le)) begin
                    miscompares++;
                    $display("[TB] FAIL %s result c%0d: got v%b e%b l%0d err%b expected v%b e%b l%0d err0",
                             nome, c, venceu, empate, linha, erro, ve, ee, le);
                end
                vectors++;
                if (db_estado !== ((c == 12) ? 4'hF : 4'h0)) begin
                    miscompares++;
                    $display("[TB] FAIL %s db_estado c%0d: got %h expected %h", nome, c, db_estado,
                             (c == 12) ? 4'hF : 4'h0);
                end
            end
        end
        vectors++;
        if (fims != 1) begin
            miscompares++;
            $display("[TB] FAIL %s fim_count: got %0d expected 1", nome, fims);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({mem_le, mem_addr, ocupado, fim_verif, venceu, empate, linha, erro, db_estado} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got le%b a%0d o%b f%b v%b e%b l%0d err%b st%h expected all 0",
                     mem_le, mem_addr, ocupado, fim_verif, venceu, empate, linha, erro, db_estado);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_row_win();
        limpa_mem();
        for (int i = 36; i <= 38; i++) mem[i] = 2'b10;
        test_verificacao(4, 1'b1, "row_win");
    endtask

    task automatic test_draw();
        logic [1:0] cells [9] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        limpa_mem();
        for (int i = 0; i < 9; i++) mem[i] = cells[i];
        test_verificacao(0, 1'b0, "draw");
    endtask

    task automatic test_antidiag_priority();
        limpa_mem();
        for (int i = 72; i <= 80; i++) mem[i] = 2'b01;
        test_verificacao(8, 1'b0, "all_cells_priority");
        limpa_mem();
        mem[74] = 2'b01; mem[76] = 2'b01; mem[78] = 2'b01;
        test_verificacao(8, 1'b0, "anti_diag");
    endtask

    task automatic test_opponent_invalid();
        logic [1:0] cells [9] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        limpa_mem();
        for (int i = 0; i < 9; i++) mem[18+i] = cells[i];
        test_verificacao(2, 1'b0, "opponent_invalid");
    endtask

    task automatic test_error(input int ms);
        int le_alto;
        le_alto = 0;
        @(negedge clock);
        iniciar_verif = 1'b1;
        macro_sel = 4'(ms);
        jogador = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            iniciar_verif = 1'b0;
            if (mem_le === 1'b1) le_alto++;
            vectors++;
            if (fim_verif !== (c == 1) || ocupado !== (c == 1)) begin
                miscompares++;
                $display("[TB] FAIL error_timing c%0d: got f%b o%b expected %b", c, fim_verif, ocupado, (c == 1));
            end
            vectors++;
            if (erro !== 1'b1 || venceu !== 1'b0 || empate !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL error_flags c%0d: got err%b v%b e%b expected err1 v0 e0", c, erro, venceu, empate);
            end
        end
        vectors++;
        if (le_alto != 0) begin
            miscompares++;
            $display("[TB] FAIL error_mem_le: got %0d high cycles expected 0", le_alto);
        end
    endtask

    task automatic test_back_to_back();
        int fims;
        logic ve, ee;
        logic [2:0] le;
        fims = 0;
        limpa_mem();
        for (int i = 0; i < 9; i++) mem[27+i] = (i % 4 == 0) ? 2'b10 : 2'b01;
        modelo(3, 1'b1, ve, ee, le);
        @(negedge clock);
        iniciar_verif = 1'b1;
        macro_sel = 4'd3;
        jogador = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            iniciar_verif = (c == 5);
            macro_sel = (c == 5) ? 4'd0 : 4'd3;
            jogador = (c == 5) ? 1'b0 : 1'b1;
            if (fim_verif === 1'b1) fims++;
        end
        vectors++;
        if (fims != 1) begin
            miscompares++;
            $display("[TB] FAIL busy_fim_count: got %0d expected 1", fims);
        end
        vectors++;
        if (venceu !== ve || empate !== ee || (ve && linha !== le)) begin
            miscompares++;
            $display("[TB] FAIL busy_result: got v%b e%b l%0d expected v%b e%b l%0d", venceu, empate, linha, ve, ee, le);
        end
    endtask

    task automatic test_reset_mid();
        int fims;
        fims = 0;
        limpa_mem();
        for (int i = 45; i <= 53; i++) mem[i] = 2'b10;
        @(negedge clock);
        iniciar_verif = 1'b1;
        macro_sel = 4'd5;
        jogador = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            iniciar_verif = 1'b0;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({mem_le, mem_addr, ocupado, fim_verif, venceu, empate, linha, erro, db_estado} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_state: got le%b a%0d o%b f%b v%b e%b l%0d err%b st%h expected all 0",
                     mem_le, mem_addr, ocupado, fim_verif, venceu, empate, linha, erro, db_estado);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (fim_verif === 1'b1 || ocupado === 1'b1) fims++;
        end
        vectors++;
        if (fims != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_activity: got %0d active cycles expected 0", fims);
        end
        test_verificacao(5, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        int ms;
        int ln;
        logic jg;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 81; i++) mem[i] = 2'($urandom_range(0, 3));
            ms = $urandom_range(0, 8);
            jg = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                ln = $urandom_range(0, 7);
                for (int k = 0; k < 3; k++) mem[ms*9 + linhas[ln][k]] = jg ? 2'b10 : 2'b01;
            end else if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 9; i++) mem[ms*9 + i] = 2'($urandom_range(1, 2));
            end
            test_verificacao(ms, jg, "random");
        end
        test_error($urandom_range(9, 15));
    endtask

    initial begin
        test_reset();
        test_row_win();
        test_draw();
        test_antidiag_priority();
        test_opponent_invalid();
        test_error(9);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
